// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit-length field.
module sha1_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  msg_data,
    input  logic         msg_vld,
    input  logic         msg_last,
    input  logic [2:0]   msg_bytes,
    output logic         msg_rdy,
    output logic [511:0] blk_data,
    output logic         blk_vld,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_rdy
);

    typedef enum logic [1:0] {
        S_FILL,
        S_OUT,
        S_OUT_X
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [31:0]  r_word [16];
    logic [3:0]   r_wcnt;
    logic [63:0]  r_bytes;
    logic         r_first;
    logic         r_vld;
    logic         r_last;
    logic         r_xpend;
    logic         r_xmark;

    logic         w_acc;
    logic         w_hs;
    logic [2:0]   w_k;
    logic [31:0]  w_keep;
    logic [31:0]  w_mark;
    logic [63:0]  w_bytes_sum;
    logic [63:0]  w_len_now;
    logic [63:0]  w_len_reg;
    logic [4:0]   w_p;
    logic         w_fits;
    logic         w_blk_done;

    assign msg_rdy     = (r_state == S_FILL) & ~rst;
    assign w_acc       = msg_vld & msg_rdy;
    assign w_hs        = r_vld & blk_rdy;
    assign blk_vld     = r_vld;
    assign blk_first   = r_first & r_vld;
    assign blk_last    = r_last;

    // Non-last words always carry 4 bytes; out-of-range counts saturate at 4.
    always_comb begin
        w_k = 3'd4;
        if (msg_last && (msg_bytes < 3'd4)) begin
            w_k = msg_bytes;
        end
    end

    always_comb begin
        w_keep = 32'hFFFF_FFFF;
        w_mark = 32'h0000_0000;
        case (w_k)
            3'd0:    begin w_keep = 32'h0000_0000; w_mark = 32'h8000_0000; end
            3'd1:    begin w_keep = 32'hFF00_0000; w_mark = 32'h0080_0000; end
            3'd2:    begin w_keep = 32'hFFFF_0000; w_mark = 32'h0000_8000; end
            3'd3:    begin w_keep = 32'hFFFF_FF00; w_mark = 32'h0000_0080; end
            default: begin w_keep = 32'hFFFF_FFFF; w_mark = 32'h0000_0000; end
        endcase
    end

    assign w_bytes_sum = r_bytes + {61'd0, w_k};
    assign w_len_now   = {w_bytes_sum[60:0], 3'b000};
    assign w_len_reg   = {r_bytes[60:0], 3'b000};
    assign w_p         = {1'b0, r_wcnt} + ((w_k == 3'd4) ? 5'd1 : 5'd0);
    assign w_fits      = (w_p <= 5'd13);
    assign w_blk_done  = w_acc & (msg_last | (r_wcnt == 4'd15));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_blk_done) w_state_nxt = S_OUT;
            S_OUT:   if (w_hs) w_state_nxt = r_xpend ? S_OUT_X : S_FILL;
            S_OUT_X: if (w_hs) w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_word[i] <= '0;
            end
            r_wcnt  <= '0;
            r_bytes <= '0;
            r_first <= 1'b1;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_xpend <= 1'b0;
            r_xmark <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_acc) begin
                        r_bytes <= w_bytes_sum;
                        if (msg_last) begin
                            r_word[r_wcnt] <= (msg_data & w_keep) | w_mark;
                            if ((w_k == 3'd4) && (r_wcnt != 4'd15)) begin
                                r_word[r_wcnt + 4'd1] <= 32'h8000_0000;
                            end
                            if (w_fits) begin
                                r_word[14] <= w_len_now[63:32];
                                r_word[15] <= w_len_now[31:0];
                            end
                            r_vld   <= 1'b1;
                            r_last  <= w_fits;
                            r_xpend <= ~w_fits;
                            r_xmark <= (w_p == 5'd16);
                        end else begin
                            r_word[r_wcnt] <= msg_data;
                            r_wcnt         <= r_wcnt + 4'd1;
                            if (r_wcnt == 4'd15) begin
                                r_vld   <= 1'b1;
                                r_last  <= 1'b0;
                                r_xpend <= 1'b0;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        // Words are cleared here so the next block starts from zero padding.
                        for (int unsigned i = 0; i < 16; i++) begin
                            r_word[i] <= '0;
                        end
                        r_first <= 1'b0;
                        if (r_xpend) begin
                            r_word[0]  <= r_xmark ? 32'h8000_0000 : 32'h0000_0000;
                            r_word[14] <= w_len_reg[63:32];
                            r_word[15] <= w_len_reg[31:0];
                            r_last     <= 1'b1;
                            r_xpend    <= 1'b0;
                        end else begin
                            r_vld  <= 1'b0;
                            r_wcnt <= '0;
                            r_last <= 1'b0;
                            if (r_last) begin
                                r_bytes <= '0;
                                r_first <= 1'b1;
                            end
                        end
                    end
                end
                S_OUT_X: begin
                    if (w_hs) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            r_word[i] <= '0;
                        end
                        r_vld   <= 1'b0;
                        r_wcnt  <= '0;
                        r_bytes <= '0;
                        r_first <= 1'b1;
                        r_last  <= 1'b0;
                        r_xmark <= 1'b0;
                    end
                end
                default: begin
                    r_vld <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        blk_data = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            blk_data[511 - 32*i -: 32] = r_word[i];
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder against a byte-level SHA-1 padding model.
module tb_sha1_padder;

    logic         clk;
    logic         rst;
    logic [31:0]  msg_data;
    logic         msg_vld;
    logic         msg_last;
    logic [2:0]   msg_bytes;
    logic         msg_rdy;
    logic [511:0] blk_data;
    logic         blk_vld;
    logic         blk_first;
    logic         blk_last;
    logic         blk_rdy;

    int n_checks = 0;
    int n_err    = 0;
    int blk_idx  = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_q[$];

    sha1_padder dut (
        .clk       (clk),
        .rst       (rst),
        .msg_data  (msg_data),
        .msg_vld   (msg_vld),
        .msg_last  (msg_last),
        .msg_bytes (msg_bytes),
        .msg_rdy   (msg_rdy),
        .blk_data  (blk_data),
        .blk_vld   (blk_vld),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_rdy   (blk_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard padding: 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_model();
        logic [7:0]   p[$];
        logic [63:0]  len;
        logic [511:0] blk;
        p = msg_q;
        len = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int b = 7; b >= 0; b--) p.push_back(len[8*b +: 8]);
        exp_q.delete();
        for (int n = 0; n < p.size() / 64; n++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk = {blk[503:0], p[64*n + j]};
            exp_q.push_back(blk);
        end
    endtask

    task automatic drain(input int stall);
        logic [511:0] e;
        int ns;
        int guard;
        guard = 0;
        while (blk_vld === 1'b1 && guard < 4) begin
            guard++;
            if (exp_q.size() == 0) begin
                chk("unexpected_blk_vld", 512'(blk_vld), 512'd0);
                e = '0;
            end else begin
                e = exp_q.pop_front();
                chk("blk_data", blk_data, e);
                chk("blk_first", 512'(blk_first), 512'(blk_idx == 0));
                chk("blk_last", 512'(blk_last), 512'(exp_q.size() == 0));
            end
            ns = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            blk_rdy = 1'b0;
            for (int s = 0; s < ns; s++) begin
                msg_vld   = 1'b1;
                msg_data  = $urandom;
                msg_last  = 1'($urandom);
                msg_bytes = 3'($urandom);
                @(posedge clk); #1;
                chk("stall_vld", 512'(blk_vld), 512'd1);
                chk("stall_data", blk_data, e);
                chk("stall_rdy", 512'(msg_rdy), 512'd0);
            end
            msg_vld = 1'b0;
            blk_rdy = 1'b1;
            @(posedge clk); #1;
            blk_rdy = 1'b0;
            blk_idx++;
        end
    endtask

    task automatic send_word(input int w, input logic last, input int k, input int stall);
        logic [31:0] d;
        int wait_cnt;
        d = $urandom;
        for (int b = 0; b < k; b++) d[31 - 8*b -: 8] = msg_q[4*w + b];
        msg_data  = d;
        msg_last  = last;
        msg_bytes = last ? 3'(k) : 3'($urandom);
        msg_vld   = 1'b1;
        wait_cnt  = 0;
        while (msg_rdy !== 1'b1 && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (wait_cnt >= 50) chk("msg_rdy_timeout", 512'(msg_rdy), 512'd1);
        @(posedge clk); #1;
        msg_vld = 1'b0;
        drain(stall);
    endtask

    task automatic send_msg(input bit marker, input int stall);
        int n;
        int nw;
        int k;
        n  = msg_q.size();
        nw = (n + 3) / 4;
        blk_idx = 0;
        if (n == 0) begin
            send_word(0, 1'b1, 0, stall);
        end else begin
            for (int w = 0; w < nw; w++) begin
                k = (n - 4*w >= 4) ? 4 : n - 4*w;
                if (w == nw - 1 && marker && k == 4) begin
                    send_word(w, 1'b0, 4, stall);
                    send_word(w + 1, 1'b1, 0, stall);
                end else begin
                    send_word(w, w == nw - 1, k, stall);
                end
            end
        end
        chk("blocks_left", 512'(exp_q.size()), 512'd0);
        chk("idle_vld", 512'(blk_vld), 512'd0);
        chk("idle_rdy", 512'(msg_rdy), 512'd1);
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        int lens[11] = '{55, 56, 57, 59, 60, 61, 63, 64, 119, 120, 128};
        rst = 1'b1; msg_vld = 1'b0; msg_data = '0; msg_last = 1'b0;
        msg_bytes = '0; blk_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_msg_rdy", 512'(msg_rdy), 512'd0);
        chk("rst_blk_vld", 512'(blk_vld), 512'd0);
        chk("rst_blk_data", blk_data, 512'd0);
        chk("rst_blk_last", 512'(blk_last), 512'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdy", 512'(msg_rdy), 512'd1);

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        exp_q.delete();
        exp_q.push_back({32'h6162_6380, 448'd0, 32'h0000_0018});
        send_msg(1'b0, 0);

        // Empty message
        msg_q.delete();
        exp_q.delete();
        exp_q.push_back({32'h8000_0000, 480'd0});
        send_msg(1'b0, 1);

        // 56 and 64 byte messages
        rand_msg(56); build_model(); send_msg(1'b0, -1);
        rand_msg(64); build_model(); send_msg(1'b0, -1);
        rand_msg(64); build_model(); send_msg(1'b1, -1);

        // Long stall on "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        exp_q.delete();
        exp_q.push_back({32'h6162_6380, 448'd0, 32'h0000_0018});
        send_msg(1'b0, 5);

        // Reset mid-message: partial data must vanish
        rand_msg(28);
        exp_q.delete();
        blk_idx = 0;
        for (int w = 0; w < 7; w++) send_word(w, 1'b0, 4, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rdy", 512'(msg_rdy), 512'd0);
        chk("midrst_vld", 512'(blk_vld), 512'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_after_rdy", 512'(msg_rdy), 512'd1);
        chk("midrst_after_vld", 512'(blk_vld), 512'd0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        exp_q.push_back({32'h6162_6380, 448'd0, 32'h0000_0018});
        send_msg(1'b0, 0);

        foreach (lens[i]) begin
            rand_msg(lens[i]); build_model(); send_msg(1'b0, -1);
            rand_msg(lens[i]); build_model(); send_msg(1'b1, -1);
        end

        for (int t = 0; t < 40; t++) begin
            rand_msg(int'($urandom_range(0, 140)));
            build_model();
            send_msg(1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
